alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, 64, operand/result width; legal values are powers of two, 8 to 64.
REQ-002 Derived constant: SHW = log2(WIDTH), the shift-amount width.
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: in_valid  in  1  operation request.
REQ-006 Port: in_ready  out  1  block can accept a request.
REQ-007 Port: op  in  8  opcode: 0x01 ADD, 0x02 SUB, 0x03 MUL, 0x04 AND, 0x05 OR, 0x06 NOT, 0x07 XOR, 0x08 SHL, 0x09 SHR, 0x0A DIV (macro-gated).
REQ-008 Port: a, b  in  WIDTH  operands.
REQ-009 Port: out_valid  out  1  result and flags are valid.
REQ-010 Port: out_ready  in  1  consumer accepts the result.
REQ-011 Port: result  out  WIDTH  operation result.
REQ-012 Port: zero_flag, negative_flag, overflow_flag, carry_flag  out  1 each  status flags.
REQ-013 Port: err_flag  out  1  illegal opcode, or divide by zero.
REQ-014 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, EXEC and DONE. in_ready SHALL equal (state==IDLE).
REQ-016 Acceptance SHALL occur when in_valid&&in_ready; at acceptance, op/a/b SHALL be registered and the FSM SHALL move to EXEC.
REQ-017 Single-cycle ops (all except MUL and DIV) SHALL compute in one EXEC cycle; out_valid SHALL rise 2 cycles after the acceptance edge.
REQ-018 MUL SHALL be an iterative unsigned shift-add with one operand bit per cycle for WIDTH cycles; result SHALL be the low WIDTH bits; out_valid SHALL rise WIDTH+1 cycles after acceptance.
REQ-019 DONE SHALL hold result and flags stable while out_ready=0, and SHALL return to IDLE on the edge where out_valid&&out_ready.
REQ-020 ADD/SUB SHALL be modulo 2^WIDTH.
REQ-021 ADD/SUB flags: carry = carry-out for ADD; carry = borrow (a<b unsigned) for SUB; overflow = signed two's-complement overflow.
REQ-022 MUL flags: overflow=1 iff the upper WIDTH bits of the full product are nonzero; carry=0.
REQ-023 Logic and shift ops (AND/OR/XOR/NOT/SHL/SHR): carry=0 and overflow=0. NOT SHALL use a only.
REQ-024 SHL/SHR SHALL be logical; the shift amount is b[SHW-1:0]; if b>=WIDTH, result SHALL be 0.
REQ-025 For every op: zero = (result==0); negative = result[WIDTH-1].
REQ-026 An illegal opcode (including 0x00) SHALL complete in the single-cycle timing with result=0, err_flag=1, zero=1 and all other flags 0.
REQ-027 err_flag SHALL be 0 for every legal op except DIV by zero.
REQ-028 in_valid while busy SHALL be ignored: no acceptance, and no corruption of the in-flight operation.

Reset
REQ-029 While rst=1: state=IDLE, out_valid=0, busy=0, result=0, all flags 0, iteration counter 0.
REQ-030 Reset asserted mid-MUL/DIV SHALL abort the operation; the first acceptance after release SHALL behave as from power-up.

Configuration
REQ-031 Macro ALU_MC_DIV_EN, when defined, SHALL add DIV (0x0A): unsigned restoring division, WIDTH iterations, result = quotient, timing as MUL.
REQ-032 DIV flags: carry=0 and overflow=0. For b=0: result = all ones, err_flag=1, and completion after the single-cycle timing.
REQ-033 With ALU_MC_DIV_EN undefined, no divider logic SHALL exist and 0x0A SHALL be handled as an illegal opcode (REQ-026).

Verification
REQ-034 WIDTH=64, ADD a=15 b=10, out_ready=1 -> result=25; out_valid 2 cycles after acceptance; all flags 0.
REQ-035 SUB a=10 b=20 -> result=0xFFFFFFFFFFFFFFF6, negative=1, carry=1, overflow=0; then ADD a=0x7FFFFFFFFFFFFFFF b=1 -> overflow=1, negative=1.
REQ-036 MUL a=3 b=4 -> result=12 at acceptance+65 cycles, in_ready=0 throughout; then MUL a=2^63 b=2 -> result=0, overflow=1, zero=1.
REQ-037 SHL a=1 b=4 -> 0x10; SHR a=0x10 b=4 -> 1; SHL a=1 b=64 -> 0, zero=1; op=0x0B -> result=0, err_flag=1.
REQ-038 Hold out_ready=0 for 5 cycles with in_valid=1 and new operands -> result stable and no acceptance; raise out_ready -> IDLE next cycle, then the new request is accepted.
REQ-039 rst pulse at iteration 10 of MUL -> outputs 0 immediately; then XOR 0xFF00..FF00 ^ 0x00FF..00FF -> all ones. With ALU_MC_DIV_EN: DIV 100/7 -> 14; DIV by 0 -> all ones, err_flag=1.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a valid/ready request side and a valid/ready
// result side. ADD/SUB/logic/shift ops finish in a fixed short time; MUL
// (and DIV when ALU_MC_DIV_EN is defined) iterate one operand bit per cycle.
//
// Optional feature macro: ALU_MC_DIV_EN adds opcode 0x0A (unsigned restoring
// divide). Without it, 0x0A is treated as an illegal opcode.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  request handshake; op/a/b captured on acceptance
//   op [7:0], a, b     opcode and WIDTH-bit operands
//   out_valid/out_ready result handshake; result/flags held while stalled
//   result             WIDTH-bit result
//   zero/negative/overflow/carry/err flags
//   busy               high whenever the FSM is not IDLE
module alu_mc #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             negative_flag,
  output logic             overflow_flag,
  output logic             carry_flag,
  output logic             err_flag,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_ITER = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  localparam logic [7:0] OP_ADD = 8'h01, OP_SUB = 8'h02, OP_MUL = 8'h03,
                         OP_AND = 8'h04, OP_OR  = 8'h05, OP_NOT = 8'h06,
                         OP_XOR = 8'h07, OP_SHL = 8'h08, OP_SHR = 8'h09,
                         OP_DIV = 8'h0A;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state_q, state_d;

  logic [7:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [SHW:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [4:0]         flags_q, flags_d;  // {zero, negative, overflow, carry, err}

  logic accept, is_iter, exec_done;
  logic [SHW:0] cnt_last;

  assign accept = in_valid && in_ready;

  // Iterative ops run WIDTH step cycles; everything else runs one.
  // The extra EXEC cycle at cnt_last latches the final result and flags.
  always_comb begin
    is_iter = (op_q == OP_MUL);
`ifdef ALU_MC_DIV_EN
    if (op_q == OP_DIV && b_q != '0) is_iter = 1'b1;
`endif
  end
  assign cnt_last  = is_iter ? CNT_ITER : CNT_ONE;
  assign exec_done = (state_q == EXEC) && (cnt_q == cnt_last);

  // Shift-add multiply step: high half accumulates, whole product shifts right
  // so the next multiplier bit lands at prod_q[0].
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
  assign mul_step = {mul_sum, prod_q[WIDTH-1:1]};

`ifdef ALU_MC_DIV_EN
  // Restoring divide step: {remainder, dividend/quotient} shifts left; the
  // quotient bit enters at the bottom. The remainder always fits WIDTH bits.
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_step;
  assign div_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, b_q});
  assign div_rem  = div_ge ? (div_sh[WIDTH-1:0] - b_q) : div_sh[WIDTH-1:0];
  assign div_step = {div_rem, prod_q[WIDTH-2:0], div_ge};
`endif

  // Final result and flags for the operation in flight.
  logic [WIDTH:0]   add_ext;
  logic [WIDTH-1:0] sub_res, fin_res;
  logic             fin_ov, fin_c, fin_err, shift_big;
  assign add_ext   = {1'b0, a_q} + {1'b0, b_q};
  assign sub_res   = a_q - b_q;
  assign shift_big = (b_q >= WIDTH);

  always_comb begin
    fin_res = '0;
    fin_ov  = 1'b0;
    fin_c   = 1'b0;
    fin_err = 1'b0;
    case (op_q)
      OP_ADD: begin
        fin_res = add_ext[WIDTH-1:0];
        fin_c   = add_ext[WIDTH];
        fin_ov  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (fin_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        fin_res = sub_res;
        fin_c   = (a_q < b_q);
        fin_ov  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (fin_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MUL: begin
        fin_res = prod_q[WIDTH-1:0];
        fin_ov  = |prod_q[2*WIDTH-1:WIDTH];
      end
      OP_AND: fin_res = a_q & b_q;
      OP_OR:  fin_res = a_q | b_q;
      OP_NOT: fin_res = ~a_q;
      OP_XOR: fin_res = a_q ^ b_q;
      OP_SHL: fin_res = shift_big ? '0 : (a_q << b_q[SHW-1:0]);
      OP_SHR: fin_res = shift_big ? '0 : (a_q >> b_q[SHW-1:0]);
`ifdef ALU_MC_DIV_EN
      OP_DIV: begin
        if (b_q == '0) begin
          fin_res = '1;
          fin_err = 1'b1;
        end else begin
          fin_res = prod_q[WIDTH-1:0];
        end
      end
`endif
      default: fin_err = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = EXEC;
      EXEC:    if (exec_done) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Operand, iteration and result next-state
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (accept) begin
      op_d   = op;
      a_d    = a;
      b_d    = b;
      cnt_d  = '0;
      prod_d = {{WIDTH{1'b0}}, b};
`ifdef ALU_MC_DIV_EN
      if (op == OP_DIV) prod_d = {{WIDTH{1'b0}}, a};
`endif
    end else if (state_q == EXEC) begin
      if (exec_done) begin
        cnt_d    = '0;
        result_d = fin_res;
        flags_d  = {(fin_res == '0), fin_res[WIDTH-1], fin_ov, fin_c, fin_err};
      end else begin
        cnt_d = cnt_q + CNT_ONE;
        if (op_q == OP_MUL) prod_d = mul_step;
`ifdef ALU_MC_DIV_EN
        if (op_q == OP_DIV) prod_d = div_step;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result        = result_q;
  assign zero_flag     = flags_q[4];
  assign negative_flag = flags_q[3];
  assign overflow_flag = flags_q[2];
  assign carry_flag    = flags_q[1];
  assign err_flag      = flags_q[0];
endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [7:0]   op;
  logic [W-1:0] a, b;
  logic         out_valid, out_ready;
  logic [W-1:0] result;
  logic         zero_flag, negative_flag, overflow_flag, carry_flag, err_flag, busy;

  int tests = 0;
  int fails = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero_flag(zero_flag), .negative_flag(negative_flag),
    .overflow_flag(overflow_flag), .carry_flag(carry_flag),
    .err_flag(err_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] dut_flags();
    return {zero_flag, negative_flag, overflow_flag, carry_flag, err_flag};
  endfunction

  // Reference model from the operation definitions, using wide arithmetic.
  function automatic void model(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic [4:0] f, output int lat);
    logic [127:0] wide;
    logic signed [W+1:0] s;
    logic c, ov, e;
    c = 1'b0; ov = 1'b0; e = 1'b0; lat = 2; r = '0;
    case (o)
      8'h01: begin
        wide = {64'd0, x} + {64'd0, y};
        r = wide[W-1:0]; c = wide[W];
        s = $signed({{2{x[W-1]}}, x}) + $signed({{2{y[W-1]}}, y});
        ov = (s > $signed({2'b00, {1'b0, {(W-1){1'b1}}}})) || (s < -$signed({2'b00, 1'b1, {(W-1){1'b0}}}));
      end
      8'h02: begin
        r = x - y; c = (x < y);
        s = $signed({{2{x[W-1]}}, x}) - $signed({{2{y[W-1]}}, y});
        ov = (s > $signed({2'b00, {1'b0, {(W-1){1'b1}}}})) || (s < -$signed({2'b00, 1'b1, {(W-1){1'b0}}}));
      end
      8'h03: begin
        wide = {64'd0, x} * {64'd0, y};
        r = wide[W-1:0]; ov = (wide[127:64] != 0); lat = W + 1;
      end
      8'h04: r = x & y;
      8'h05: r = x | y;
      8'h06: r = ~x;
      8'h07: r = x ^ y;
      8'h08: r = (y >= W) ? '0 : x << y;
      8'h09: r = (y >= W) ? '0 : x >> y;
`ifdef ALU_MC_DIV_EN
      8'h0A: begin
        if (y == 0) begin r = '1; e = 1'b1; end
        else begin r = x / y; lat = W + 1; end
      end
`endif
      default: begin r = '0; e = 1'b1; end
    endcase
    f = {(r == 0), r[W-1], ov, c, e};
  endfunction

  // Issue one op with out_ready=1 and check result, flags, latency, in_ready.
  task automatic run_op(input string tag, input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] er;
    logic [4:0] ef;
    int lat, n;
    bit rdy_low;
    model(o, x, y, er, ef, lat);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0; rdy_low = 1'b1;
    while (!out_valid && n < 200) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); #1; n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_res"}, result, er);
    check({tag, "_flg"}, dut_flags(), ef);
    if (lat > 2) check({tag, "_rdy"}, rdy_low, 1'b1);
    @(posedge clk); #1;
    check({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [7:0] ro;
    logic [W-1:0] ra, rb;
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {out_valid, busy, in_ready, dut_flags()}, {3'b001, 5'b0});
    check("rst_res", result, 0);
    @(negedge clk); rst = 1'b0;

    run_op("add", 8'h01, 15, 10);
    run_op("sub", 8'h02, 10, 20);
    run_op("add_ov", 8'h01, 64'h7FFF_FFFF_FFFF_FFFF, 1);
    run_op("mul", 8'h03, 3, 4);
    run_op("mul_ov", 8'h03, 64'h8000_0000_0000_0000, 2);
    run_op("shl", 8'h08, 1, 4);
    run_op("shr", 8'h09, 64'h10, 4);
    run_op("shl_big", 8'h08, 1, 64);
    run_op("ill_0b", 8'h0B, 5, 6);
    run_op("ill_00", 8'h00, 5, 6);
    run_op("not", 8'h06, 64'h0F0F, 64'hFFFF);
    run_op("div_op", 8'h0A, 100, 7);
    run_op("div_zero", 8'h0A, 100, 0);

    // Stall in DONE while a new request is presented.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; op = 8'h01; a = 5; b = 6;
    @(posedge clk); #1;
    op = 8'h02; a = 9; b = 3;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("hold_lat", n, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_stable", {out_valid, in_ready, result}, {2'b10, 64'd11});
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release", {out_valid, in_ready}, 2'b01);
    @(posedge clk); #1;
    check("hold_accept", busy, 1'b1);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("hold_new_res", result, 6);
    @(posedge clk); #1;

    // Reset in the middle of a multiply.
    @(negedge clk);
    in_valid = 1'b1; op = 8'h03; a = 3; b = 4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid", {out_valid, busy, in_ready, dut_flags()}, {3'b001, 5'b0});
    check("rst_mid_res", result, 0);
    @(negedge clk); rst = 1'b0;
    run_op("xor", 8'h07, 64'hFF00_FF00_FF00_FF00, 64'h00FF_00FF_00FF_00FF);
    run_op("mul_after_rst", 8'h03, 7, 9);

    // Randomized ops against the model.
    for (int i = 0; i < 40; i++) begin
      ro = 8'($urandom_range(0, 11));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ((ro == 8'h08 || ro == 8'h09) && $urandom_range(0, 3) != 0) rb = W'($urandom_range(0, 70));
      if (ro == 8'h0A && $urandom_range(0, 3) == 0) rb = '0;
      if ($urandom_range(0, 3) == 0) ra = W'($urandom_range(0, 300));
      run_op("rand", ro, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
